// File: rtl/rr_mux.sv
// N-channel, W-bit multiplexer with a single registered output stage.
// Picks a fixed channel (sel) or the next round-robin requester and forwards its word one cycle later.
module rr_mux #(
    parameter int CH = 4,
    parameter int W  = 1,
    parameter int SW = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          mode,
    input  logic [SW-1:0] sel,
    input  logic [CH*W-1:0] in_data,
    input  logic [CH-1:0] in_valid,
    output logic [CH-1:0] in_ready,
    output logic [W-1:0]  out_data,
    output logic [SW-1:0] out_ch,
    output logic          out_valid,
    input  logic          out_ready
);

    // Handshake rule: a transfer happens on a rising edge where valid and ready are both high;
    // in_ready depends on out_ready, outputs come straight from registers.

    logic [W-1:0]  r_out_data;
    logic [SW-1:0] r_out_ch;
    logic          r_out_valid;
    logic [SW-1:0] r_ptr;

    logic          w_grant_vld;
    logic [SW-1:0] w_grant_idx;
    logic          w_free;
    logic          w_load;
    logic [SW-1:0] w_ptr_nxt;
    logic [W-1:0]  w_data;

    // Round-robin search is split into two passes: ptr..CH-1, then 0..ptr-1.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        if (mode == 1'b0) begin
            for (int i = 0; i < CH; i++) begin
                if (sel == SW'(i)) begin
                    w_grant_vld = in_valid[i];
                    w_grant_idx = SW'(i);
                end
            end
        end else begin
            for (int i = 0; i < CH; i++) begin
                if (!w_grant_vld && in_valid[i] && (SW'(i) >= r_ptr)) begin
                    w_grant_vld = 1'b1;
                    w_grant_idx = SW'(i);
                end
            end
            for (int i = 0; i < CH; i++) begin
                if (!w_grant_vld && in_valid[i] && (SW'(i) < r_ptr)) begin
                    w_grant_vld = 1'b1;
                    w_grant_idx = SW'(i);
                end
            end
        end
    end

    assign w_free = ~r_out_valid | out_ready;
    assign w_load = en & w_free & w_grant_vld;
    assign w_ptr_nxt = (w_grant_idx == SW'(CH - 1)) ? '0 : w_grant_idx + SW'(1);

    always_comb begin
        w_data   = '0;
        in_ready = '0;
        for (int i = 0; i < CH; i++) begin
            if (w_grant_idx == SW'(i)) begin
                w_data      = in_data[i*W +: W];
                in_ready[i] = w_load;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data  <= '0;
            r_out_ch    <= '0;
            r_out_valid <= 1'b0;
            r_ptr       <= '0;
        end else if (w_load) begin
            r_out_data  <= w_data;
            r_out_ch    <= w_grant_idx;
            r_out_valid <= 1'b1;
            if (mode) begin
                r_ptr <= w_ptr_nxt;
            end
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_data  = r_out_data;
    assign out_ch    = r_out_ch;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_rr_mux.sv
// Directed bench for rr_mux: a CH=4 instance for round-robin/fixed/backpressure/reset,
// and a CH=6 instance for out-of-range select.
module tb_rr_mux;

    logic clk;
    logic rst_n;

    logic        a_en, a_mode, a_out_ready, a_out_valid;
    logic [1:0]  a_sel, a_out_ch;
    logic [15:0] a_in_data;
    logic [3:0]  a_in_valid, a_in_ready, a_out_data;

    logic        b_en, b_mode, b_out_ready, b_out_valid;
    logic [2:0]  b_sel, b_out_ch;
    logic [23:0] b_in_data;
    logic [5:0]  b_in_valid, b_in_ready;
    logic [3:0]  b_out_data;

    int total = 0;
    int bad   = 0;

    rr_mux #(.CH(4), .W(4)) u_a (
        .clk(clk), .rst_n(rst_n), .en(a_en), .mode(a_mode), .sel(a_sel),
        .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .out_data(a_out_data), .out_ch(a_out_ch), .out_valid(a_out_valid),
        .out_ready(a_out_ready)
    );

    rr_mux #(.CH(6), .W(4)) u_b (
        .clk(clk), .rst_n(rst_n), .en(b_en), .mode(b_mode), .sel(b_sel),
        .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .out_data(b_out_data), .out_ch(b_out_ch), .out_valid(b_out_valid),
        .out_ready(b_out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout obs=running exp=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One transfer on instance A: check ready before the edge, output after it.
    task automatic beat(input string tag, input logic [3:0] exp_rdy,
                        input logic [1:0] exp_ch, input logic [3:0] exp_dat);
        chk({tag, "_rdy"}, 32'(a_in_ready), 32'(exp_rdy));
        tick();
        chk({tag, "_ch"},  32'(a_out_ch), 32'(exp_ch));
        chk({tag, "_dat"}, 32'(a_out_data), 32'(exp_dat));
        chk({tag, "_vld"}, 32'(a_out_valid), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        a_en = 1'b0; a_mode = 1'b0; a_sel = '0; a_in_data = '0; a_in_valid = '0; a_out_ready = 1'b0;
        b_en = 1'b0; b_mode = 1'b0; b_sel = '0; b_in_data = '0; b_in_valid = '0; b_out_ready = 1'b1;
        tick();
        tick();
        chk("rst_vld", 32'(a_out_valid), 32'd0);
        chk("rst_dat", 32'(a_out_data), 32'd0);
        chk("rst_ch",  32'(a_out_ch), 32'd0);
        chk("rst_rdy", 32'(a_in_ready), 32'd0);
        rst_n = 1'b1;
        tick();

        // Round-robin, all requesting: 0,1,2,3,0 back to back
        a_mode = 1'b1; a_en = 1'b1; a_out_ready = 1'b1;
        a_in_valid = 4'b1111;
        a_in_data = {4'd3, 4'd2, 4'd1, 4'd0};
        #1;
        beat("rr0", 4'b0001, 2'd0, 4'd0);
        beat("rr1", 4'b0010, 2'd1, 4'd1);
        beat("rr2", 4'b0100, 2'd2, 4'd2);
        beat("rr3", 4'b1000, 2'd3, 4'd3);
        beat("rr4", 4'b0001, 2'd0, 4'd0);

        // ptr = 1; channels 1 and 3 alternate
        a_in_valid = 4'b1010;
        #1;
        beat("alt0", 4'b0010, 2'd1, 4'd1);
        beat("alt1", 4'b1000, 2'd3, 4'd3);
        beat("alt2", 4'b0010, 2'd1, 4'd1);
        beat("alt3", 4'b1000, 2'd3, 4'd3);

        a_in_valid = 4'b0010;
        #1;
        beat("solo0", 4'b0010, 2'd1, 4'd1);
        beat("solo1", 4'b0010, 2'd1, 4'd1);
        beat("solo2", 4'b0010, 2'd1, 4'd1);

        // Fixed select; ptr stays at 2
        a_mode = 1'b0; a_sel = 2'd2; a_in_valid = 4'b1111;
        #1;
        beat("fix0", 4'b0100, 2'd2, 4'd2);
        beat("fix1", 4'b0100, 2'd2, 4'd2);
        beat("fix2", 4'b0100, 2'd2, 4'd2);

        // Backpressure: 0xA from ch1 held for 3 cycles
        a_mode = 1'b1; a_in_valid = 4'b0010;
        a_in_data = {4'd3, 4'd2, 4'hA, 4'd0};
        #1;
        beat("bp_ld", 4'b0010, 2'd1, 4'hA);
        a_out_ready = 1'b0; a_in_valid = 4'b1111;
        #1;
        beat("bp0", 4'b0000, 2'd1, 4'hA);
        beat("bp1", 4'b0000, 2'd1, 4'hA);
        beat("bp2", 4'b0000, 2'd1, 4'hA);
        a_out_ready = 1'b1;
        #1;
        beat("bp_rel", 4'b0100, 2'd2, 4'd2);

        // Enable low: held word drains, nothing accepted, ptr frozen at 3
        a_en = 1'b0;
        #1;
        chk("en0_rdy", 32'(a_in_ready), 32'd0);
        tick();
        chk("en0_vld", 32'(a_out_valid), 32'd0);
        chk("en0_dat", 32'(a_out_data), 32'd2);
        chk("en0_ch",  32'(a_out_ch), 32'd2);
        chk("en0_rdy2", 32'(a_in_ready), 32'd0);
        tick();
        chk("en0_vld2", 32'(a_out_valid), 32'd0);
        a_en = 1'b1;
        #1;
        beat("en1", 4'b1000, 2'd3, 4'd3);

        // Asynchronous reset while a word is held with ptr = 3
        a_in_valid = 4'b0100;
        #1;
        beat("pre_rst", 4'b0100, 2'd2, 4'd2);
        a_out_ready = 1'b0; a_in_valid = 4'b1111;
        #1;
        chk("hold_rdy", 32'(a_in_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_vld", 32'(a_out_valid), 32'd0);
        chk("arst_dat", 32'(a_out_data), 32'd0);
        chk("arst_ch",  32'(a_out_ch), 32'd0);
        tick();
        rst_n = 1'b1;
        a_out_ready = 1'b1;
        #1;
        beat("post_rst", 4'b0001, 2'd0, 4'd0);

        // CH = 6: sel = 5 selects the last channel, sel = 7 grants nothing
        a_en = 1'b0;
        b_en = 1'b1; b_mode = 1'b0; b_sel = 3'd5; b_in_valid = 6'b111111;
        b_in_data = {4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
        #1;
        chk("b5_rdy", 32'(b_in_ready), 32'b100000);
        tick();
        chk("b5_ch",  32'(b_out_ch), 32'd5);
        chk("b5_dat", 32'(b_out_data), 32'd5);
        chk("b5_vld", 32'(b_out_valid), 32'd1);
        b_sel = 3'd7;
        #1;
        chk("b7_rdy", 32'(b_in_ready), 32'd0);
        tick();
        chk("b7_vld", 32'(b_out_valid), 32'd0);
        chk("b7_ch",  32'(b_out_ch), 32'd5);
        tick();
        chk("b7_vld2", 32'(b_out_valid), 32'd0);
        chk("b7_rdy2", 32'(b_in_ready), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
